// File: rtl/ghr_checkpoint_unit.sv
// Speculative global history register with an in-order checkpoint FIFO.
// It restores the history on a branch mispredict or a pipeline flush.
module ghr_checkpoint_unit #(
  parameter int unsigned GHR_WIDTH  = 8,
  parameter int unsigned CKPT_DEPTH = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                          i_Clk,
  input  logic                          i_Reset,
  input  logic                          i_Pred_Valid,
  input  logic                          i_Prediction,
  input  logic                          i_Resolve_Valid,
  input  logic                          i_Resolve_Outcome,
  input  logic                          i_Resolve_Mispredict,
  input  logic                          i_Flush,
  output logic [GHR_WIDTH-1:0]          o_Global_History,
  output logic [GHR_WIDTH-1:0]          o_Committed_History,
  output logic                          o_Full,
  output logic                          o_Empty,
  output logic [$clog2(CKPT_DEPTH):0]   o_Inflight,
  output logic                          o_Underflow,
  output logic [CNT_WIDTH-1:0]          o_Mispredict_Count
);

  localparam int unsigned PtrW = $clog2(CKPT_DEPTH);
  localparam logic [PtrW:0] OccFull = (PtrW+1)'(CKPT_DEPTH);

  logic [GHR_WIDTH-1:0] spec_q, spec_d;
  logic [GHR_WIDTH-1:0] comm_q, comm_d;
  logic [GHR_WIDTH-1:0] snap_q [CKPT_DEPTH];
  logic [PtrW-1:0]      head_q, head_d;
  logic [PtrW-1:0]      tail_q, tail_d;
  logic [PtrW:0]        occ_q, occ_d;
  logic                 underflow_q, underflow_d;
  logic [CNT_WIDTH-1:0] mis_cnt_q, mis_cnt_d;

  logic empty, full, res_en, mis_en, pop_en, push_en;

  always_comb begin
    empty   = (occ_q == '0);
    full    = (occ_q == OccFull);
    res_en  = i_Resolve_Valid && !empty;
    mis_en  = res_en && i_Resolve_Mispredict;
    pop_en  = res_en && !i_Resolve_Mispredict && !i_Flush;
    // A same-cycle pop frees a slot, so a push is accepted even when full.
    push_en = i_Pred_Valid && (!full || pop_en) && !mis_en && !i_Flush;

    comm_d      = res_en ? {comm_q[GHR_WIDTH-2:0], i_Resolve_Outcome} : comm_q;
    underflow_d = i_Resolve_Valid && empty;
    mis_cnt_d   = (mis_en && (mis_cnt_q != '1)) ? mis_cnt_q + CNT_WIDTH'(1) : mis_cnt_q;

    spec_d = spec_q;
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;

    if (i_Flush) begin
      // Flush restores from the committed history, including this cycle's resolve.
      spec_d = comm_d;
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
    end else if (mis_en) begin
      spec_d = {snap_q[head_q][GHR_WIDTH-2:0], i_Resolve_Outcome};
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
    end else begin
      if (push_en) begin
        spec_d = {spec_q[GHR_WIDTH-2:0], i_Prediction};
        tail_d = tail_q + PtrW'(1);
      end
      if (pop_en) begin
        head_d = head_q + PtrW'(1);
      end
      occ_d = occ_q + (PtrW+1)'(push_en) - (PtrW+1)'(pop_en);
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      spec_q      <= '1;
      comm_q      <= '1;
      head_q      <= '0;
      tail_q      <= '0;
      occ_q       <= '0;
      underflow_q <= 1'b0;
      mis_cnt_q   <= '0;
    end else begin
      spec_q      <= spec_d;
      comm_q      <= comm_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      occ_q       <= occ_d;
      underflow_q <= underflow_d;
      mis_cnt_q   <= mis_cnt_d;
    end
  end

  // Snapshot storage needs no reset; occupancy alone marks entries valid.
  always_ff @(posedge i_Clk) begin
    if (push_en) begin
      snap_q[tail_q] <= spec_q;
    end
  end

  assign o_Global_History    = spec_q;
  assign o_Committed_History = comm_q;
  assign o_Full              = full;
  assign o_Empty             = empty;
  assign o_Inflight          = occ_q;
  assign o_Underflow         = underflow_q;
  assign o_Mispredict_Count  = mis_cnt_q;

endmodule

// File: tb/tb_ghr_checkpoint_unit.sv
// Randomized and directed checks of ghr_checkpoint_unit against a queue-based model.
module tb_ghr_checkpoint_unit;

  localparam int Depth = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pred_valid = 1'b0, prediction = 1'b0;
  logic       res_valid = 1'b0, res_outcome = 1'b0, res_mispredict = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] ghr, comm;
  logic       full, empty, underflow;
  logic [2:0] inflight;
  logic [15:0] mis_cnt;
  logic [7:0] s_ghr, s_comm;
  logic       s_full, s_empty, s_underflow;
  logic [2:0] s_inflight;
  logic [1:0] s_mis_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [7:0] m_spec, m_comm;
  logic [7:0] m_q[$];
  int         m_cnt;
  bit         m_uf;

  always #5 clk = ~clk;

  ghr_checkpoint_unit #(.GHR_WIDTH(8), .CKPT_DEPTH(Depth), .CNT_WIDTH(16)) u_dut (
    .i_Clk(clk), .i_Reset(rst), .i_Pred_Valid(pred_valid), .i_Prediction(prediction),
    .i_Resolve_Valid(res_valid), .i_Resolve_Outcome(res_outcome),
    .i_Resolve_Mispredict(res_mispredict), .i_Flush(flush),
    .o_Global_History(ghr), .o_Committed_History(comm), .o_Full(full), .o_Empty(empty),
    .o_Inflight(inflight), .o_Underflow(underflow), .o_Mispredict_Count(mis_cnt)
  );

  ghr_checkpoint_unit #(.GHR_WIDTH(8), .CKPT_DEPTH(Depth), .CNT_WIDTH(2)) u_dut_sat (
    .i_Clk(clk), .i_Reset(rst), .i_Pred_Valid(pred_valid), .i_Prediction(prediction),
    .i_Resolve_Valid(res_valid), .i_Resolve_Outcome(res_outcome),
    .i_Resolve_Mispredict(res_mispredict), .i_Flush(flush),
    .o_Global_History(s_ghr), .o_Committed_History(s_comm), .o_Full(s_full),
    .o_Empty(s_empty), .o_Inflight(s_inflight), .o_Underflow(s_underflow),
    .o_Mispredict_Count(s_mis_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_update(input bit r, pv, pr, rv, ro, rm, fl);
    bit         res, is_full;
    logic [7:0] new_comm;
    m_uf = 1'b0;
    if (r) begin
      m_spec = 8'hFF;
      m_comm = 8'hFF;
      m_q.delete();
      m_cnt = 0;
      return;
    end
    m_uf     = rv && (m_q.size() == 0);
    res      = rv && (m_q.size() != 0);
    new_comm = res ? {m_comm[6:0], ro} : m_comm;
    if (res && rm) m_cnt++;
    if (fl) begin
      m_spec = new_comm;
      m_q.delete();
    end else if (res && rm) begin
      m_spec = {m_q[0][6:0], ro};
      m_q.delete();
    end else begin
      is_full = (m_q.size() == Depth);
      if (res) void'(m_q.pop_front());
      if (pv && (!is_full || res)) begin
        m_q.push_back(m_spec);
        m_spec = {m_spec[6:0], pr};
      end
    end
    m_comm = new_comm;
  endtask

  task automatic step(input bit r, pv, pr, rv, ro, rm, fl);
    int exp_sat;
    rst = r; pred_valid = pv; prediction = pr;
    res_valid = rv; res_outcome = ro; res_mispredict = rm; flush = fl;
    @(posedge clk);
    model_update(r, pv, pr, rv, ro, rm, fl);
    #1;
    exp_sat = (m_cnt > 3) ? 3 : m_cnt;
    check_eq("ghr", 32'(ghr), 32'(m_spec));
    check_eq("committed", 32'(comm), 32'(m_comm));
    check_eq("inflight", 32'(inflight), 32'(m_q.size()));
    check_eq("full", 32'(full), 32'(m_q.size() == Depth));
    check_eq("empty", 32'(empty), 32'(m_q.size() == 0));
    check_eq("underflow", 32'(underflow), 32'(m_uf));
    check_eq("mis_cnt", 32'(mis_cnt), 32'((m_cnt > 65535) ? 65535 : m_cnt));
    check_eq("mis_cnt_sat", 32'(s_mis_cnt), 32'(exp_sat));
  endtask

  initial begin
    // Reset, then pushes 1,0,1
    step(1, 0, 0, 0, 0, 0, 0);
    check_eq("reset_ghr", 32'(ghr), 32'h FF);
    check_eq("reset_empty", 32'(empty), 32'd1);
    step(0, 1, 1, 0, 0, 0, 0);
    check_eq("push1", 32'(ghr), 32'hFF);
    step(0, 1, 0, 0, 0, 0, 0);
    check_eq("push0", 32'(ghr), 32'hFE);
    step(0, 1, 1, 0, 0, 0, 0);
    check_eq("push1b", 32'(ghr), 32'hFD);
    check_eq("inflight3", 32'(inflight), 32'd3);

    // Fill, push while full, then push with a correct resolve
    step(0, 1, 0, 0, 0, 0, 0);
    check_eq("full_set", 32'(full), 32'd1);
    step(0, 1, 1, 0, 0, 0, 0);
    check_eq("push_full_ignored", 32'(ghr), 32'hFA);
    check_eq("full_stays", 32'(full), 32'd1);
    step(0, 1, 1, 1, 1, 0, 0);
    check_eq("push_pop_full", 32'(inflight), 32'd4);
    check_eq("push_pop_ghr", 32'(ghr), 32'hF5);

    // Two correct resolves then flush
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    check_eq("flush_ghr", 32'(ghr), 32'hFE);
    check_eq("flush_comm", 32'(comm), 32'hFE);

    // Underflow pulse; mispredict drops same-cycle push
    step(0, 0, 0, 1, 1, 0, 0);
    check_eq("underflow_pulse", 32'(underflow), 32'd1);
    step(0, 0, 0, 0, 0, 0, 0);
    check_eq("underflow_clear", 32'(underflow), 32'd0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 1, 1, 0);
    check_eq("mp_push_dropped", 32'(inflight), 32'd0);

    // Build 0xA5, then push, push, mispredict
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    for (int i = 6; i >= 0; i--) step(0, 1, 1'((8'hA5 >> i) & 1), 1, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);
    check_eq("ghr_a5", 32'(ghr), 32'hA5);
    step(0, 1, 1, 0, 0, 0, 0);
    check_eq("ghr_4b", 32'(ghr), 32'h4B);
    step(0, 1, 1, 0, 0, 0, 0);
    check_eq("ghr_97", 32'(ghr), 32'h97);
    step(0, 0, 0, 1, 0, 1, 0);
    check_eq("mp_restore", 32'(ghr), 32'h4A);
    check_eq("mp_count1", 32'(mis_cnt), 32'd1);

    // Saturation of the 2-bit counter, then reset mid-stream
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 1, 1, 0);
    end
    check_eq("sat_count", 32'(s_mis_cnt), 32'd3);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 1, 0, 1, 1);
    check_eq("midrst_count", 32'(mis_cnt), 32'd0);
    check_eq("midrst_inflight", 32'(inflight), 32'd0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 99) < 60), 1'($urandom),
           ($urandom_range(0, 99) < 40), 1'($urandom),
           ($urandom_range(0, 99) < 25),
           ($urandom_range(0, 39) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ghr_checkpoint_unit.md
# ghr_checkpoint_unit

Speculative global history register with in-order branch checkpointing and misprediction recovery, for the gshare predictor front end. Shifts the predicted direction into a speculative history at DEC, keeps a FIFO of pre-shift snapshots for every in-flight branch, and at EX resolution either retires the oldest snapshot or restores the history from it with the actual outcome. Also maintains the committed (architectural) history, used as the recovery point for an external pipeline flush.

## Interface
- GHR_WIDTH, 8, history length in bits (≥2); output width and table index width.
- CKPT_DEPTH, 4, maximum in-flight unresolved branches; power of two, ≥2.
- CNT_WIDTH, 16, width of the misprediction counter.
- i_Clk  in  1  clock; all state updates on rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_Pred_Valid  in  1  branch at DEC stage; push request.
- i_Prediction  in  1  predicted direction from counter table (1 = taken).
- i_Resolve_Valid  in  1  oldest in-flight branch resolving at EX.
- i_Resolve_Outcome  in  1  actual direction.
- i_Resolve_Mispredict  in  1  outcome ≠ prediction; meaningful only with i_Resolve_Valid.
- i_Flush  in  1  pipeline flush (exception/redirect not from a branch).
- o_Global_History  out  GHR_WIDTH  speculative history, registered readout.
- o_Committed_History  out  GHR_WIDTH  history of resolved branches only.
- o_Full  out  1  CKPT_DEPTH entries in flight; DEC must stall.
- o_Empty  out  1  no entries in flight.
- o_Inflight  out  log2(CKPT_DEPTH)+1  occupancy.
- o_Underflow  out  1  one-cycle pulse: resolve seen while empty.
- o_Mispredict_Count  out  CNT_WIDTH  saturating count of mispredicts.

## Operation
- Reset: speculative and committed history = all ones (taken default); FIFO pointers and occupancy = 0; o_Empty=1, o_Full=0, o_Underflow=0, count=0. Reset has priority over every other input.
- Push (i_Pred_Valid, not full, no higher-priority event): store current speculative history at tail; speculative ← {history[GHR_WIDTH-2:0], i_Prediction}; occupancy +1.
- Push while full: ignored, no state change; stalling is upstream responsibility.
- Resolve correct (i_Resolve_Valid, !i_Resolve_Mispredict, not empty): pop head; committed ← {committed[GHR_WIDTH-2:0], i_Resolve_Outcome}; speculative unchanged.
- Resolve mispredict (not empty): speculative ← {head_snapshot[GHR_WIDTH-2:0], i_Resolve_Outcome}; FIFO emptied (all younger entries are wrong-path); committed shifts as for correct resolve; count +1, saturating at all ones.
- Resolve while empty: ignored except o_Underflow pulses high next cycle.
- Flush (i_Flush): speculative ← committed (pre-update value, plus any same-cycle resolve shift applied); FIFO emptied.
- Priority per cycle: reset > flush = mispredict (both empty FIFO; flush restore value = updated committed, overriding mispredict restore) > resolve-correct/push.
- Resolve-correct and push same cycle: both happen; occupancy unchanged; a push is accepted even when full because the pop frees a slot.
- Push in same cycle as mispredict or flush: dropped (wrong path).
- Pointers wrap modulo CKPT_DEPTH; occupancy distinguishes full from empty.

## Timing
- All outputs registered or decoded directly from registers; no combinational path from inputs to outputs.
- Push/restore latency: 1 cycle; new speculative history visible on o_Global_History the cycle after the event.
- DEC must sample o_Full in the same cycle it would assert i_Pred_Valid; o_Full reflects state at the start of the cycle (no same-cycle pop credit advertised).
- o_Underflow high exactly one cycle per bad resolve.
- Reset mid-operation discards all in-flight snapshots in one cycle.

## Test plan
- Reset then three pushes with predictions 1,0,1 (GHR_WIDTH=8) -> o_Global_History 0xFF→0xFF→0xFE→0xFD; o_Inflight=3.
- From history 0xA5, push pred 1 (→0x4B), push pred 1 (→0x97), resolve oldest mispredict outcome 0 -> o_Global_History=0x4A, o_Empty=1, count=1, committed shifted by 0.
- Fill to CKPT_DEPTH, assert push alone -> ignored, o_Full stays 1; push plus resolve-correct same cycle -> accepted, occupancy stays at CKPT_DEPTH.
- Two correct resolves (outcomes 1,0) then i_Flush -> o_Global_History equals o_Committed_History = 0xFE, FIFO empty.
- Resolve with o_Empty=1 -> o_Underflow pulses one cycle, histories unchanged; mispredict with simultaneous push -> push dropped, o_Inflight=0.
- Force CNT_WIDTH=2, four mispredicts -> count saturates at 3; i_Reset asserted mid-stream -> all outputs return to reset values next cycle.
